// File: rtl/alu.sv
// 32-bit MIPS integer ALU with registered result, zero/overflow/carry flags.
// One-cycle latency, fully pipelined, no back-pressure.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic [3:0]  alu_op,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        carry,
  output logic        out_valid
);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD  = 4'h2, OP_ADDU = 4'h3,
    OP_XOR  = 4'h4, OP_NOR  = 4'h5, OP_SUB  = 4'h6, OP_SLT  = 4'h7,
    OP_SUBU = 4'h8, OP_SLTU = 4'h9, OP_SLL  = 4'hA, OP_SRL  = 4'hB,
    OP_SRA  = 4'hC, OP_SLLV = 4'hD, OP_SRLV = 4'hE, OP_SRAV = 4'hF
  } alu_op_e;

  alu_op_e     op;
  logic        sub_mode;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        sum_ovf;
  logic        slt_bit;
  logic [4:0]  shift_amt;
  logic [31:0] next_result;
  logic        next_overflow;
  logic        next_carry;

  assign op = alu_op_e'(alu_op);

  // One shared adder: subtraction and both compares use a + ~b + 1.
  always_comb begin
    sub_mode = (op == OP_SUB) || (op == OP_SUBU) || (op == OP_SLT) || (op == OP_SLTU);
    b_eff    = sub_mode ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub_mode};
    sum_ovf  = (a[31] == b_eff[31]) && (sum[31] != a[31]);
  end

  // Sign of the true difference: raw sign bit corrected by overflow.
  assign slt_bit   = (op == OP_SLTU) ? ~sum[32] : (sum[31] ^ sum_ovf);
  assign shift_amt = ((op == OP_SLLV) || (op == OP_SRLV) || (op == OP_SRAV)) ? a[4:0] : shamt;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch can be inferred.
  always_comb begin
    next_result   = 32'd0;
    next_overflow = 1'b0;
    next_carry    = 1'b0;
    unique case (op)
      OP_AND:  next_result = a & b;
      OP_OR:   next_result = a | b;
      OP_XOR:  next_result = a ^ b;
      OP_NOR:  next_result = ~(a | b);
      OP_ADD, OP_SUB: begin
        next_result   = sum[31:0];
        next_overflow = sum_ovf;
        next_carry    = sum[32];
      end
      OP_ADDU, OP_SUBU: begin
        next_result = sum[31:0];
        next_carry  = sum[32];
      end
      OP_SLT, OP_SLTU: next_result = {31'd0, slt_bit};
      OP_SLL, OP_SLLV: next_result = b << shift_amt;
      OP_SRL, OP_SRLV: next_result = b >> shift_amt;
      OP_SRA, OP_SRAV: next_result = $unsigned($signed(b) >>> shift_amt);
      default: next_result = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= 32'd0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= next_result;
        zero     <= (next_result == 32'd0);
        overflow <= next_overflow;
        carry    <= next_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset corner case,
// back-to-back throughput against an independent 64-bit reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [3:0]  alu_op;
  logic        in_valid;
  logic [31:0] result;
  logic        zero, overflow, carry, out_valid;

  int checks   = 0;
  int failures = 0;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .alu_op   (alu_op),
    .in_valid (in_valid),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .carry    (carry),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_result;
    logic        exp_ovf;
    logic        exp_carry;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference built on 64-bit signed/unsigned arithmetic rather than flag logic.
  task automatic model(input logic [3:0] op, input logic [31:0] ma, input logic [31:0] mb,
                       input logic [4:0] sh, output logic [31:0] r, output logic o,
                       output logic c);
    longint          sa, sb, ss;
    longint unsigned ua, ub, us;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'd0, ma};
    ub = {32'd0, mb};
    r = 32'd0; o = 1'b0; c = 1'b0;
    case (op)
      4'h0: r = ma & mb;
      4'h1: r = ma | mb;
      4'h4: r = ma ^ mb;
      4'h5: r = ~(ma | mb);
      4'h2, 4'h3: begin
        ss = sa + sb; us = ua + ub;
        r = ss[31:0];
        c = us[32];
        if (op == 4'h2) o = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'h6, 4'h8: begin
        ss = sa - sb;
        r = ss[31:0];
        c = (ma >= mb);
        if (op == 4'h6) o = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: r = (ua < ub) ? 32'd1 : 32'd0;
      4'hA: r = mb << sh;
      4'hB: r = mb >> sh;
      4'hC: r = $unsigned($signed(mb) >>> sh);
      4'hD: r = mb << ma[4:0];
      4'hE: r = mb >> ma[4:0];
      default: r = $unsigned($signed(mb) >>> ma[4:0]);
    endcase
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] sh);
    in_valid = 1'b1;
    alu_op   = op;
    a        = va;
    b        = vb;
    shamt    = sh;
  endtask

  task automatic check_outputs(input string name, input logic [31:0] er, input logic eo,
                               input logic ec);
    check({name, ".result"},    result,           er);
    check({name, ".zero"},      {31'd0, zero},     {31'd0, er == 32'd0});
    check({name, ".overflow"},  {31'd0, overflow}, {31'd0, eo});
    check({name, ".carry"},     {31'd0, carry},    {31'd0, ec});
    check({name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] er, held;
    logic        eo, ec;

    vecs.push_back('{"add_ovf",   4'h2, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0});
    vecs.push_back('{"addu_novf", 4'h3, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{"add_wrap",  4'h2, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{"sub_eq",    4'h6, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{"sub_ovf",   4'h6, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b1});
    vecs.push_back('{"subu_brw",  4'h8, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"slt_neg",   4'h7, 32'h80000000, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{"sltu_big",  4'h9, 32'h80000000, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"slt_ovf",   4'h7, 32'h7FFFFFFF, 32'h80000000, 5'd0,  32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"sra",       4'hC, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0});
    vecs.push_back('{"srl",       4'hB, 32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0});
    vecs.push_back('{"sllv",      4'hD, 32'hFFFFFFE3, 32'h00000001, 5'd0,  32'h00000008, 1'b0, 1'b0});
    vecs.push_back('{"sll_lui",   4'hA, 32'h00000000, 32'h00001234, 5'd16, 32'h12340000, 1'b0, 1'b0});
    vecs.push_back('{"and",       4'h0, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0,  32'h00F0F000, 1'b0, 1'b0});
    vecs.push_back('{"or",        4'h1, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0});
    vecs.push_back('{"xor",       4'h4, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0,  32'hFF000FF0, 1'b0, 1'b0});
    vecs.push_back('{"nor_ones",  4'h5, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"nor_zero",  4'h5, 32'hFFFFFFFF, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"srav",      4'hF, 32'hFFFFFFE4, 32'h80000000, 5'd0,  32'hF8000000, 1'b0, 1'b0});
    vecs.push_back('{"srlv",      4'hE, 32'h0000001F, 32'h80000000, 5'd0,  32'h00000001, 1'b0, 1'b0});

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; shamt = '0; alu_op = '0;
    #1;
    check("reset0.result",    result,             32'd0);
    check("reset0.out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed table, issued back-to-back.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shamt);
      @(posedge clk); #1;
      check_outputs(vecs[i].name, vecs[i].exp_result, vecs[i].exp_ovf, vecs[i].exp_carry);
    end

    // Gap in in_valid: out_valid drops, result and flags hold.
    held = result;
    in_valid = 1'b0;
    drive(4'h5, 32'h0, 32'h0, 5'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("gap.out_valid", {31'd0, out_valid}, 32'd0);
    check("gap.result",    result,             held);

    // Throughput: all 16 opcodes with random operands, one per cycle.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      logic [4:0]  rs;
      ra = $urandom; rb = $urandom; rs = 5'($urandom_range(31, 0));
      model(4'(i), ra, rb, rs, er, eo, ec);
      drive(4'(i), ra, rb, rs);
      @(posedge clk); #1;
      check_outputs($sformatf("b2b%0d", i), er, eo, ec);
    end
    in_valid = 1'b0;
    held = result;
    repeat (2) @(posedge clk); #1;
    check("b2b_gap.out_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_gap.result",    result,             held);

    // Reset mid-cycle with an op in flight: outputs clear immediately.
    drive(4'h1, 32'h0000FFFF, 32'hFFFF0000, 5'd0);
    @(posedge clk); #1;
    check("pre_rst.result", result, 32'hFFFFFFFF);
    drive(4'h2, 32'h00000010, 32'h00000020, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async.result",    result,             32'd0);
    check("rst_async.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async.flags",     {29'd0, zero, overflow, carry}, 32'd0);
    @(posedge clk); #1;
    check("rst_hold.result", result, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst.result",    result,             32'd0);

    // First accepted op after release.
    drive(4'h2, 32'h00000010, 32'h00000020, 5'd0);
    @(posedge clk); #1;
    check_outputs("post_rst_add", 32'h00000030, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
